// File: rtl/regfile_wsel.sv
// 32 x WIDTH register file driven by an active-low one-hot write select.
// Register 0 reads as zero. A multi-hot select is dropped and sets a sticky error flag.
module regfile_wsel #(
    parameter int WIDTH  = 32,
    parameter int BYPASS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [31:0]      wsel_n,
    input  logic [WIDTH-1:0] wdata,
    input  logic [4:0]       raddr1,
    input  logic [4:0]       raddr2,
    output logic [WIDTH-1:0] rdata1,
    output logic [WIDTH-1:0] rdata2,
    output logic             wsel_err,
    output logic [15:0]      wr_count
);

    logic [WIDTH-1:0] regs [32];
    logic [4:0]       zcount;
    logic [4:0]       widx;
    logic             commit;
    logic             multi;

    // Bit 0 is skipped because register 0 can never be written.
    // widx is only meaningful when zcount == 1.
    always_comb begin
        zcount = '0;
        widx   = '0;
        for (int i = 1; i < 32; i++) begin
            if (!wsel_n[i]) begin
                zcount = zcount + 5'd1;
                widx   = i[4:0];
            end
        end
    end

    assign commit = we && (zcount == 5'd1);
    assign multi  = we && (zcount > 5'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
            wsel_err <= 1'b0;
            wr_count <= '0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (commit && widx == i[4:0]) regs[i] <= wdata;
            end
            if (commit) wr_count <= wr_count + 16'd1;
            if (multi)  wsel_err <= 1'b1;
        end
    end

    always_comb begin
        rdata1 = regs[raddr1];
        rdata2 = regs[raddr2];
        // Forward the write data for a write that commits on the coming edge.
        if (BYPASS != 0 && commit && raddr1 == widx) rdata1 = wdata;
        if (BYPASS != 0 && commit && raddr2 == widx) rdata2 = wdata;
        if (raddr1 == 5'd0) rdata1 = '0;
        if (raddr2 == 5'd0) rdata2 = '0;
    end

endmodule

// File: tb/tb_regfile_wsel.sv
// Directed bench for regfile_wsel: one bypassing and one non-bypassing instance share stimulus.
module tb_regfile_wsel;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [31:0] wsel_n;
    logic [31:0] wdata;
    logic [4:0]  raddr1, raddr2;
    logic [31:0] b_rd1, b_rd2, n_rd1, n_rd2;
    logic        b_err, n_err;
    logic [15:0] b_cnt, n_cnt;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    regfile_wsel #(.WIDTH(32), .BYPASS(1)) u_byp (
        .clk(clk), .rst(rst), .we(we), .wsel_n(wsel_n), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(b_rd1), .rdata2(b_rd2),
        .wsel_err(b_err), .wr_count(b_cnt)
    );

    regfile_wsel #(.WIDTH(32), .BYPASS(0)) u_nbyp (
        .clk(clk), .rst(rst), .we(we), .wsel_n(wsel_n), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(n_rd1), .rdata2(n_rd2),
        .wsel_err(n_err), .wr_count(n_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs are changed 1 time unit after a rising edge; outputs are sampled there too.
    task automatic wr(input logic [31:0] sel, input logic [31:0] data);
        we = 1'b1; wsel_n = sel; wdata = data;
        @(posedge clk); #1;
        we = 1'b0; wsel_n = 32'hFFFF_FFFF;
    endtask

    task automatic rd1(input logic [4:0] a, input string tag, input logic [31:0] exp);
        raddr1 = a; #1;
        chk(tag, b_rd1, exp);
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; wsel_n = 32'hFFFF_FFFF; wdata = '0;
        raddr1 = 5'd1; raddr2 = 5'd31;
        #12;
        chk("rst_cnt", {16'd0, b_cnt}, 32'd0);
        chk("rst_err", {31'd0, b_err}, 32'd0);
        chk("rst_rd1", b_rd1, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        wr(32'hFFFF_FFFD, 32'hDEAD_BEEF);
        rd1(5'd1, "wr_r1", 32'hDEAD_BEEF);
        chk("cnt_1", {16'd0, b_cnt}, 32'd1);
        wr(32'h7FFF_FFFF, 32'h1234_5678);
        raddr2 = 5'd31; #1;
        chk("wr_r31", b_rd2, 32'h1234_5678);
        chk("cnt_2", {16'd0, b_cnt}, 32'd2);
        chk("r1_kept", b_rd1, 32'hDEAD_BEEF);

        // register 0 and all-ones select: no write, no count, no error
        wr(32'hFFFF_FFFE, 32'hFFFF_FFFF);
        rd1(5'd0, "r0_zero", 32'd0);
        chk("r0_cnt", {16'd0, b_cnt}, 32'd2);
        chk("r0_err", {31'd0, b_err}, 32'd0);
        wr(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("noop_cnt", {16'd0, b_cnt}, 32'd2);
        chk("noop_err", {31'd0, b_err}, 32'd0);
        rd1(5'd1, "noop_r1", 32'hDEAD_BEEF);

        // multi-hot on regs 2 and 3
        wr(32'hFFFF_FFFB, 32'hA5A5_A5A5);
        wr(32'hFFFF_FFF7, 32'h3333_3333);
        chk("cnt_4", {16'd0, b_cnt}, 32'd4);
        wr(32'hFFFF_FFF3, 32'h0);
        rd1(5'd2, "mh_r2", 32'hA5A5_A5A5);
        rd1(5'd3, "mh_r3", 32'h3333_3333);
        chk("mh_err", {31'd0, b_err}, 32'd1);
        chk("mh_cnt", {16'd0, b_cnt}, 32'd4);
        for (int i = 0; i < 10; i++) wr(32'hFFFF_FFEF, i);
        chk("err_sticky", {31'd0, b_err}, 32'd1);
        chk("cnt_14", {16'd0, b_cnt}, 32'd14);
        rd1(5'd4, "r4_last", 32'd9);

        // bypass vs stored path on reg 5
        wr(32'hFFFF_FFDF, 32'h0000_0055);
        raddr1 = 5'd5; raddr2 = 5'd5;
        we = 1'b1; wsel_n = 32'hFFFF_FFDF; wdata = 32'h0000_00AA; #1;
        chk("byp_rd1", b_rd1, 32'h0000_00AA);
        chk("byp_rd2", b_rd2, 32'h0000_00AA);
        chk("nbyp_old1", n_rd1, 32'h0000_0055);
        chk("nbyp_old2", n_rd2, 32'h0000_0055);
        raddr2 = 5'd0; #1;
        chk("byp_r0", b_rd2, 32'd0);
        @(posedge clk); #1;
        we = 1'b0; wsel_n = 32'hFFFF_FFFF;
        raddr2 = 5'd5; #1;
        chk("nbyp_new", n_rd1, 32'h0000_00AA);
        chk("byp_new", b_rd2, 32'h0000_00AA);
        chk("nbyp_cnt", {16'd0, n_cnt}, 32'd16);
        // multi-hot touching reg 5 must not be forwarded
        we = 1'b1; wsel_n = 32'hFFFF_FFDB; wdata = 32'h0000_0077; #1;
        chk("byp_mh", b_rd1, 32'h0000_00AA);
        we = 1'b0; wsel_n = 32'hFFFF_FFFF;

        // asynchronous reset between edges
        @(posedge clk); #3;
        rst = 1'b1; #1;
        chk("arst_cnt", {16'd0, b_cnt}, 32'd0);
        chk("arst_err", {31'd0, b_err}, 32'd0);
        chk("arst_nerr", {31'd0, n_err}, 32'd0);
        for (int a = 0; a < 32; a++) begin
            raddr1 = a[4:0]; raddr2 = a[4:0]; #1;
            chk("arst_rd1", b_rd1, 32'd0);
            chk("arst_rd2", n_rd2, 32'd0);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // counter wrap, with an idle cycle before the final write
        we = 1'b1; wsel_n = 32'hFFFF_FFBF; wdata = 32'h6666_6666;
        repeat (65535) @(posedge clk);
        #1;
        chk("cnt_ffff", {16'd0, b_cnt}, 32'h0000_FFFF);
        we = 1'b0;
        @(posedge clk); #1;
        chk("cnt_idle", {16'd0, b_cnt}, 32'h0000_FFFF);
        wr(32'hFFFF_FFBF, 32'h6666_6667);
        chk("cnt_wrap", {16'd0, b_cnt}, 32'd0);
        rd1(5'd6, "wrap_r6", 32'h6666_6667);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_wsel.md
# regfile_wsel

32 × 32-bit general-purpose register file for the 55-instruction MIPS CPU. It sits directly downstream of the register-write decoder and consumes its 32-bit active-low write-select vector. It provides two combinational read ports with optional same-cycle write bypass. Register 0 is hardwired to zero, and any malformed (multi-hot) select vector is blocked and flagged.

## Interface
Parameters:
- WIDTH, 32, data width of every register.
- BYPASS, 1, 1 = a read of the register being written returns the write data in the same cycle; 0 = the read returns the stored value.

Ports:
- clk, input, 1, system clock; all writes occur on the rising edge.
- rst, input, 1, asynchronous, active-high reset.
- we, input, 1, write enable, active-high; qualifies wsel_n.
- wsel_n, input, 32, active-low write select from the decoder:
  - bit i = 0 selects register i;
  - all-ones = no write.
- wdata, input, WIDTH, write data.
- raddr1, input, 5, read port 1 address.
- raddr2, input, 5, read port 2 address.
- rdata1, output, WIDTH, read port 1 data (combinational).
- rdata2, output, WIDTH, read port 2 data (combinational).
- wsel_err, output, 1, sticky flag: a write was attempted with more than one select bit low.
- wr_count, output, 16, number of committed writes since reset; wraps at 0xFFFF→0x0000.

## Operation
- Reset (rst=1, asynchronous):
  - all 32 registers clear to 0;
  - wsel_err clears to 0;
  - wr_count clears to 0;
  - rdata1/rdata2 therefore read 0.
- Select decode, evaluated every cycle:
  - zcount = number of zero bits in wsel_n[31:1];
  - wsel_n[0] is ignored because register 0 is never writable.
- Write commit: occurs on a rising clk edge when we=1 and zcount==1.
  - The selected register i (1..31) loads wdata.
  - wr_count increments by 1.
- No write: when we=0, or zcount==0 (all-ones, or only bit 0 low).
  - No register changes and wr_count holds.
  - wsel_err is unaffected.
- Multi-hot select: when we=1 and zcount≥2.
  - No register is written and wr_count holds.
  - wsel_err sets to 1 on that edge and stays 1 until rst.
- Read:
  - rdataN = reg[raddrN] combinationally.
  - raddrN==0 always returns 0, regardless of BYPASS or any write.
- Bypass (BYPASS=1): the read returns wdata in the same cycle when a write will commit this cycle (per the rules above) to register i and raddrN==i≠0.
- No bypass (BYPASS=0), or a write that will not commit: the read returns the stored value.
- Both read ports are independent and may address the same register.
- wr_count arithmetic is unsigned 16-bit modulo 2^16.

## Timing
- Write latency: 1 clock. Data written at edge k is visible at the read ports immediately after edge k (stored path).
- With BYPASS=1 the written data is also visible in the cycle before edge k.
- Read latency: 0 cycles (combinational from raddrN, and from wdata/wsel_n/we when BYPASS=1).
- wsel_err and wr_count update only on rising clk edges, except for asynchronous reset.
- Reset asserted mid-write: the reset wins and the register stays 0.
- Reset deasserted: the first write can commit on the first rising edge with rst=0.
- No handshake and no back-pressure: every qualifying edge commits.

## Test plan
- Reset: pulse rst asynchronously between edges -> rdata1=rdata2=0 for all 32 addresses, wsel_err=0, wr_count=0 with no clock edge required.
- Basic write/read: we=1, wsel_n=32'hFFFF_FFFD (reg 1), wdata=32'hDEAD_BEEF, one edge -> raddr1=1 gives rdata1=32'hDEAD_BEEF, wr_count=1.
  - Repeat with wsel_n=32'h7FFF_FFFF, wdata=32'h1234_5678 -> reg 31 reads 32'h1234_5678, wr_count=2.
- Register 0 protection: we=1, wsel_n=32'hFFFF_FFFE (and separately 32'hFFFF_FFFF), wdata=32'hFFFF_FFFF -> raddr1=0 reads 0, wr_count unchanged, wsel_err=0.
- Multi-hot: reg 2 holds 32'hA5A5_A5A5. Drive we=1, wsel_n=32'hFFFF_FFF3 (regs 2 and 3), wdata=32'h0 -> reg 2 still reads 32'hA5A5_A5A5, reg 3 unchanged, wsel_err=1.
  - wsel_err stays 1 through 10 further valid writes; only rst clears it.
- Bypass: BYPASS=1, raddr1=raddr2=5, wsel_n selects reg 5, wdata=32'h0000_00AA, we=1 -> rdata1=rdata2=32'h0000_00AA before the edge.
  - Same stimulus with BYPASS=0 -> the old value before the edge and 32'h0000_00AA after it.
- Counter wrap: perform 65536 committed writes -> wr_count returns to 0x0000. A we=0 cycle in between -> no increment.
